vector_exec_unit: RTL and testbench
===================================

// Module: vector_exec_unit
// PURPOSE
//  Parametrised multicycle vector engine: LANES x ELEM_W vector regfile with VLOAD, VSTORE and VADD.
//  Generalises the fixed 4x8-bit vector path to any lane count and element width.
//  Sits beside the scalar datapath. The scalar FSM issues start/op and reads done.
//  Shares the single-port data memory; the scalar FSM must not touch memory while busy=1.
// PARAMETERS
//  LANES      4   elements per vector, >=1
//  ELEM_W     8   bits per element
//  ADDR_W     8   memory address width
//  NUM_VREGS  4   vector register count, power of two >=2
//  VR_AW      $clog2(NUM_VREGS)   derived; not overridden
// PORTS
//  clock      in   1              rising-edge clock
//  reset      in   1              asynchronous, active-high
//  start      in   1              issue request; sampled only in IDLE
//  op         in   2              00 VLOAD, 01 VSTORE, 10 VADD, 11 illegal
//  vdst       in   VR_AW          destination vreg (VLOAD/VADD); first operand (VADD)
//  vsrc       in   VR_AW          source vreg (VSTORE); second operand (VADD)
//  base_addr  in   ADDR_W         element-0 address (VLOAD/VSTORE)
//  busy       out  1              request in progress
//  done       out  1              1-cycle completion pulse
//  err        out  1              1-cycle pulse with done when op==11
//  vzero      out  1              all lanes of last VADD result ==0
//  mem_addr   out  ADDR_W         memory address
//  mem_wdata  out  ELEM_W         memory write data
//  mem_wren   out  1              memory write enable
//  mem_rdata  in   ELEM_W         memory read data; registered, valid 1 cycle after mem_addr
//  dbg_sel    in   VR_AW          debug read select
//  dbg_vec    out  LANES*ELEM_W   combinational view of vreg[dbg_sel]
// BEHAVIOUR
//  Reset: all vregs=0, state IDLE, busy/done/err/vzero/mem_wren=0, mem_addr=0, mem_wdata=0.
//  Lane k occupies bits [k*ELEM_W +: ELEM_W] and maps to address base_addr+k.
//  Address arithmetic is mod 2^ADDR_W: base=8'hFF, lane 1 -> 8'h00.
//  Operands (op, vdst, vsrc, base_addr) are latched at start; later input changes are ignored.
//  start while busy=1 is ignored. No queueing.
//  FSM: IDLE, LOAD, LDRAIN, STORE, ADD, WB, DONE.
//  IDLE + start: op00->LOAD, op01->STORE, op10->ADD, op11->DONE (err=1, no state or memory change).
//  LOAD: k=0..LANES-1, one lane per cycle, mem_addr=base+k. The rdata of the previous cycle is captured
//   into staging lane k-1. LDRAIN captures lane LANES-1. Then WB.
//  STORE: k=0..LANES-1, mem_wren=1, mem_addr=base+k, mem_wdata=vreg[vsrc] lane k. Then DONE.
//  ADD: one cycle. Per lane, staging = vreg[vdst]+vreg[vsrc], ELEM_W-bit. Then WB.
//  WB: staging is written to vreg[vdst] at the end of the cycle. VADD also updates vzero here. Then DONE.
//  DONE: done=1 for one cycle, then IDLE. busy is 1 from the cycle after start through DONE.
//  Busy cycles: VLOAD LANES+3, VSTORE LANES+1, VADD 3, illegal 1.
//  VADD with vdst==vsrc is legal and doubles the register.
//  A VLOAD to a vreg is not visible on dbg_vec until the cycle after WB.
//  mem_wren is 1 only in STORE. Outside LOAD/STORE, mem_addr holds its last value.
//  Reset mid-operation aborts at once: no partial vreg write, mem_wren drops asynchronously.
//  The lane counter width is $clog2(LANES+1). No counter overflow is possible.
// CONFIGURATION
//  VEC_SAT_EN defined: VADD saturates unsigned per lane (sum > 2^ELEM_W-1 -> all-ones).
//   vzero is computed on the saturated result.
//  VEC_SAT_EN undefined: VADD wraps mod 2^ELEM_W, carries discarded.
// STRUCTURE
//  vec_pkg holds:
//   - op encodings: VOP_LOAD, VOP_STORE, VOP_ADD, VOP_ILL
//   - FSM state typedef
//   - lane-slice helper function
//  vec_regfile sub-module: NUM_VREGS x LANES*ELEM_W, async clear.
//   - 2 combinational read ports, 1 debug read port, 1 synchronous write port.
//  The engine instantiates vec_regfile plus its FSM, lane counter, staging register and per-lane adders.
// TESTING (defaults LANES=4, ELEM_W=8 unless stated)
//  1. mem[10..13]=01,02,03,04. VLOAD vdst=1, base=10 -> dbg_vec(1)=32'h04030201.
//     busy lasts 7 cycles, then one done pulse.
//  2. v1=32'h04030201. VSTORE vsrc=1, base=8'hFE.
//     -> writes FE=01, FF=02, 00=03, 01=04 (address wrap). mem_wren high exactly 4 cycles.
//  3. v1=32'hFF807F01, v2=32'h01808001. VADD vdst=1, vsrc=2:
//     - without VEC_SAT_EN: v1=32'h0000FF02
//     - with VEC_SAT_EN: v1=32'hFFFFFF02
//     - vzero=0 in both cases
//  4. v0=0. VADD vdst=0, vsrc=0 -> vzero=1, busy 3 cycles.
//     Then op=11 -> done and err pulse together, no vreg or memory change.
//  5. Assert start again during a VLOAD -> ignored.
//     Assert reset during LOAD cycle 2 -> all vregs 0, busy=0, no memory write.
//  6. LANES=8, ELEM_W=16: VLOAD then VSTORE round-trip to a new base.
//     -> memory image matches, busy counts 11 and 9.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared definitions for the vector execution engine.
//   - vec_op_e    : operation encodings driven on the op port
//   - vec_state_e : engine FSM states
//   - lane_lsb()  : bit position of lane k inside a packed LANES*ELEM_W vector
package vec_pkg;

    typedef enum logic [1:0] {
        VOP_LOAD  = 2'b00,
        VOP_STORE = 2'b01,
        VOP_ADD   = 2'b10,
        VOP_ILL   = 2'b11
    } vec_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_LDRAIN = 3'd2,
        ST_STORE  = 3'd3,
        ST_ADD    = 3'd4,
        ST_WB     = 3'd5,
        ST_DONE   = 3'd6
    } vec_state_e;

    // Lane k occupies bits [k*elem_w +: elem_w].
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned elem_w);
        return lane * elem_w;
    endfunction

endpackage

// File: rtl/vec_regfile.sv
// Vector register file: NUM_VREGS entries of LANES*ELEM_W bits, cleared by reset.
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high clear
//   we, waddr, wdata    synchronous write port
//   raddr_a / rdata_a   combinational read port A
//   raddr_b / rdata_b   combinational read port B
//   dbg_sel / dbg_vec   combinational debug read port
module vec_regfile #(
    parameter  int LANES     = 4,
    parameter  int ELEM_W    = 8,
    parameter  int NUM_VREGS = 4,
    localparam int VR_AW     = $clog2(NUM_VREGS),
    localparam int VW        = LANES * ELEM_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic [VR_AW-1:0] waddr,
    input  logic [VW-1:0]    wdata,
    input  logic [VR_AW-1:0] raddr_a,
    output logic [VW-1:0]    rdata_a,
    input  logic [VR_AW-1:0] raddr_b,
    output logic [VW-1:0]    rdata_b,
    input  logic [VR_AW-1:0] dbg_sel,
    output logic [VW-1:0]    dbg_vec
);

    logic [VW-1:0] regs_q [NUM_VREGS];
    logic [VW-1:0] regs_d [NUM_VREGS];

    // Next register contents: only the addressed entry changes on a write.
    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[waddr] = wdata;
        end else begin
            regs_d[waddr] = regs_q[waddr];
        end
    end

    // Register storage with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_VREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata_a = regs_q[raddr_a];
    assign rdata_b = regs_q[raddr_b];
    assign dbg_vec = regs_q[dbg_sel];

endmodule

// File: rtl/vector_exec_unit.sv
// Multicycle vector engine beside the scalar datapath: VLOAD / VSTORE / VADD over a
// LANES x ELEM_W vector register file, sharing the single-port data memory.
// Ports:
//   clock, reset                  rising-edge clock, asynchronous active-high reset
//   start, op, vdst, vsrc,        issue request and operands (latched in IDLE)
//   base_addr
//   busy, done, err, vzero        status (done/err are one-cycle pulses)
//   mem_addr, mem_wdata,          data memory master; mem_rdata is registered and
//   mem_wren, mem_rdata           valid one cycle after mem_addr
//   dbg_sel, dbg_vec              combinational view of vreg[dbg_sel]
// Build option: define VEC_SAT_EN for unsigned per-lane saturating VADD; default wraps.
module vector_exec_unit
    import vec_pkg::*;
#(
    parameter  int LANES     = 4,
    parameter  int ELEM_W    = 8,
    parameter  int ADDR_W    = 8,
    parameter  int NUM_VREGS = 4,
    localparam int VR_AW     = $clog2(NUM_VREGS)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [1:0]              op,
    input  logic [VR_AW-1:0]        vdst,
    input  logic [VR_AW-1:0]        vsrc,
    input  logic [ADDR_W-1:0]       base_addr,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    vzero,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [ELEM_W-1:0]       mem_wdata,
    output logic                    mem_wren,
    input  logic [ELEM_W-1:0]       mem_rdata,
    input  logic [VR_AW-1:0]        dbg_sel,
    output logic [LANES*ELEM_W-1:0] dbg_vec
);

    localparam int VW    = LANES * ELEM_W;
    // One extra count value lets LDRAIN address staging lane LANES-1 as cnt-1.
    localparam int CNT_W = $clog2(LANES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LANES - 1);

    vec_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    vec_op_e           op_q, op_d;
    logic [VR_AW-1:0]  vdst_q, vdst_d;
    logic [VR_AW-1:0]  vsrc_q, vsrc_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [VW-1:0]     staging_q, staging_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              vzero_q, vzero_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ELEM_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_wren_q, mem_wren_d;

    logic [VW-1:0]     rd_a;
    logic [VW-1:0]     rd_b;
    logic [VW-1:0]     add_res;
    logic              capture;

    // Port B follows vsrc_d so STORE can present lane 0 data on the cycle it is issued.
    vec_regfile #(
        .LANES     (LANES),
        .ELEM_W    (ELEM_W),
        .NUM_VREGS (NUM_VREGS)
    ) u_regfile (
        .clock   (clock),
        .reset   (reset),
        .we      (state_q == ST_WB),
        .waddr   (vdst_q),
        .wdata   (staging_q),
        .raddr_a (vdst_q),
        .rdata_a (rd_a),
        .raddr_b (vsrc_d),
        .rdata_b (rd_b),
        .dbg_sel (dbg_sel),
        .dbg_vec (dbg_vec)
    );

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam int LSB = lane_lsb(k, ELEM_W);
        logic [ELEM_W:0] sum;
        assign sum = {1'b0, rd_a[LSB +: ELEM_W]} + {1'b0, rd_b[LSB +: ELEM_W]};
`ifdef VEC_SAT_EN
        assign add_res[LSB +: ELEM_W] = sum[ELEM_W] ? {ELEM_W{1'b1}} : sum[ELEM_W-1:0];
`else
        assign add_res[LSB +: ELEM_W] = sum[ELEM_W-1:0];
`endif
    end

    // Operand latch: capture request fields only when a start is accepted in IDLE.
    always_comb begin
        op_d   = op_q;
        vdst_d = vdst_q;
        vsrc_d = vsrc_q;
        base_d = base_q;
        if (state_q == ST_IDLE && start) begin
            op_d   = vec_op_e'(op);
            vdst_d = vdst;
            vsrc_d = vsrc;
            base_d = base_addr;
        end else begin
            op_d   = op_q;
        end
    end

    // FSM next state, lane counter, staging register and vzero update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        staging_d = staging_q;
        vzero_d   = vzero_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    case (vec_op_e'(op))
                        VOP_LOAD:  state_d = ST_LOAD;
                        VOP_STORE: state_d = ST_STORE;
                        VOP_ADD:   state_d = ST_ADD;
                        default:   state_d = ST_DONE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_LDRAIN;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_LDRAIN: state_d = ST_WB;
            ST_STORE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_STORE;
                end
            end
            ST_ADD: begin
                staging_d = add_res;
                state_d   = ST_WB;
            end
            ST_WB: begin
                if (op_q == VOP_ADD) begin
                    vzero_d = (staging_q == '0);
                end else begin
                    vzero_d = vzero_q;
                end
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Read data lags the address by one cycle, so counter value c fills lane c-1.
        capture = (state_q == ST_LOAD) || (state_q == ST_LDRAIN);
        for (int k = 0; k < LANES; k++) begin
            staging_d[k*ELEM_W +: ELEM_W] = (capture && cnt_q == CNT_W'(k + 1)) ?
                                            mem_rdata : staging_d[k*ELEM_W +: ELEM_W];
        end
    end

    // Registered outputs derived from the upcoming state; mem_addr/mem_wdata hold when unused.
    always_comb begin
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
        err_d      = (state_d == ST_DONE) && (op_d == VOP_ILL);
        mem_wren_d = (state_d == ST_STORE);
        if (state_d == ST_LOAD || state_d == ST_STORE) begin
            mem_addr_d = base_d + ADDR_W'(cnt_d);
        end else begin
            mem_addr_d = mem_addr_q;
        end
        mem_wdata_d = mem_wdata_q;
        for (int k = 0; k < LANES; k++) begin
            mem_wdata_d = (state_d == ST_STORE && cnt_d == CNT_W'(k)) ?
                          rd_b[k*ELEM_W +: ELEM_W] : mem_wdata_d;
        end
    end

    // State and output registers; reset aborts any operation immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= VOP_LOAD;
            vdst_q      <= '0;
            vsrc_q      <= '0;
            base_q      <= '0;
            staging_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            vzero_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wren_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            vdst_q      <= vdst_d;
            vsrc_q      <= vsrc_d;
            base_q      <= base_d;
            staging_q   <= staging_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            vzero_q     <= vzero_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wren_q  <= mem_wren_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign vzero     = vzero_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wren  = mem_wren_q;

endmodule

// File: tb/tb_vector_exec_unit.sv
// Directed bench for vector_exec_unit: a default 4x8 instance and an 8x16 instance,
// each with a registered-read memory model. Expected values are hand-computed.
module tb_vector_exec_unit;

    logic         clock = 1'b0;
    logic         reset;

    // 4 x 8 instance
    logic         start;
    logic [1:0]   op, vdst, vsrc, dbg_sel;
    logic [7:0]   base_addr;
    logic         busy, done, err, vzero, mem_wren;
    logic [7:0]   mem_addr, mem_wdata, mem_rdata;
    logic [31:0]  dbg_vec;
    logic [7:0]   mem [256];
    logic         tb_we;
    logic [7:0]   tb_waddr, tb_wdata;

    // 8 x 16 instance
    logic         start8;
    logic [1:0]   op8, vdst8, vsrc8, dbg_sel8;
    logic [7:0]   base_addr8;
    logic         busy8, done8, err8, vzero8, mem_wren8;
    logic [7:0]   mem_addr8;
    logic [15:0]  mem_wdata8, mem_rdata8;
    logic [127:0] dbg_vec8;
    logic [15:0]  mem8 [256];
    logic         tb_we8;
    logic [7:0]   tb_waddr8;
    logic [15:0]  tb_wdata8;

    int total = 0;
    int bad   = 0;
    int bc, dc, ec, wc;

    always #5 clock = ~clock;

    vector_exec_unit u_dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .vdst(vdst), .vsrc(vsrc),
        .base_addr(base_addr), .busy(busy), .done(done), .err(err), .vzero(vzero),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
        .mem_rdata(mem_rdata), .dbg_sel(dbg_sel), .dbg_vec(dbg_vec)
    );

    vector_exec_unit #(.LANES(8), .ELEM_W(16), .ADDR_W(8), .NUM_VREGS(4)) u_dut8 (
        .clock(clock), .reset(reset), .start(start8), .op(op8), .vdst(vdst8), .vsrc(vsrc8),
        .base_addr(base_addr8), .busy(busy8), .done(done8), .err(err8), .vzero(vzero8),
        .mem_addr(mem_addr8), .mem_wdata(mem_wdata8), .mem_wren(mem_wren8),
        .mem_rdata(mem_rdata8), .dbg_sel(dbg_sel8), .dbg_vec(dbg_vec8)
    );

    always @(posedge clock) begin
        mem_rdata <= mem[mem_addr];
        if (mem_wren) mem[mem_addr] <= mem_wdata;
        else if (tb_we) mem[tb_waddr] <= tb_wdata;
    end

    always @(posedge clock) begin
        mem_rdata8 <= mem8[mem_addr8];
        if (mem_wren8) mem8[mem_addr8] <= mem_wdata8;
        else if (tb_we8) mem8[tb_waddr8] <= tb_wdata8;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clock); tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
        @(negedge clock); tb_we = 1'b0;
    endtask

    task automatic poke8(input logic [7:0] a, input logic [15:0] d);
        @(negedge clock); tb_we8 = 1'b1; tb_waddr8 = a; tb_wdata8 = d;
        @(negedge clock); tb_we8 = 1'b0;
    endtask

    // Issue one request, then scramble the inputs and tally busy/done/err/wren cycles.
    task automatic issue(input logic [1:0] o, input logic [1:0] d, input logic [1:0] s,
                         input logic [7:0] b, input bit restart,
                         output int bcyc, output int dcnt, output int ecnt, output int wcnt);
        @(negedge clock); start = 1'b1; op = o; vdst = d; vsrc = s; base_addr = b;
        @(negedge clock); start = 1'b0; op = 2'b10; vdst = ~d; vsrc = ~s; base_addr = ~b;
        bcyc = 0; dcnt = 0; ecnt = 0; wcnt = 0;
        for (int i = 0; i < 64; i++) begin
            if (!busy) break;
            bcyc++;
            if (done) dcnt++;
            if (err) ecnt++;
            if (mem_wren) wcnt++;
            start = (restart && i == 1) ? 1'b1 : 1'b0;
            @(negedge clock);
        end
        start = 1'b0;
    endtask

    task automatic issue8(input logic [1:0] o, input logic [1:0] d, input logic [1:0] s,
                          input logic [7:0] b, output int bcyc, output int wcnt);
        @(negedge clock); start8 = 1'b1; op8 = o; vdst8 = d; vsrc8 = s; base_addr8 = b;
        @(negedge clock); start8 = 1'b0; op8 = 2'b11; base_addr8 = ~b;
        bcyc = 0; wcnt = 0;
        for (int i = 0; i < 64; i++) begin
            if (!busy8) break;
            bcyc++;
            if (mem_wren8) wcnt++;
            @(negedge clock);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; vdst = 2'd0; vsrc = 2'd0; base_addr = 8'h00;
        dbg_sel = 2'd0; tb_we = 1'b0; tb_waddr = 8'h00; tb_wdata = 8'h00;
        start8 = 1'b0; op8 = 2'b00; vdst8 = 2'd0; vsrc8 = 2'd0; base_addr8 = 8'h00;
        dbg_sel8 = 2'd0; tb_we8 = 1'b0; tb_waddr8 = 8'h00; tb_wdata8 = 16'h0000;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'h00;
            mem8[i] = 16'h0000;
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Reset state
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_vzero", vzero, 1'b0);
        check("rst_wren", mem_wren, 1'b0);
        check("rst_addr", mem_addr, 8'h00);
        check("rst_wdata", mem_wdata, 8'h00);
        check("rst_dbg", dbg_vec, 32'h0);

        poke(8'd10, 8'h01); poke(8'd11, 8'h02); poke(8'd12, 8'h03); poke(8'd13, 8'h04);
        poke(8'd20, 8'h01); poke(8'd21, 8'h7F); poke(8'd22, 8'h80); poke(8'd23, 8'hFF);
        poke(8'd24, 8'h01); poke(8'd25, 8'h80); poke(8'd26, 8'h80); poke(8'd27, 8'h01);

        // 1: VLOAD v1 from 10
        issue(2'b00, 2'd1, 2'd0, 8'd10, 1'b0, bc, dc, ec, wc);
        check("ld_busy", bc, 7);
        check("ld_done", dc, 1);
        check("ld_err", ec, 0);
        check("ld_wren", wc, 0);
        dbg_sel = 2'd1; #1;
        check("ld_v1", dbg_vec, 32'h04030201);

        // 2: VSTORE v1 to FE with address wrap
        issue(2'b01, 2'd0, 2'd1, 8'hFE, 1'b0, bc, dc, ec, wc);
        check("st_busy", bc, 5);
        check("st_wren", wc, 4);
        check("st_done", dc, 1);
        check("st_memFE", mem[8'hFE], 8'h01);
        check("st_memFF", mem[8'hFF], 8'h02);
        check("st_mem00", mem[8'h00], 8'h03);
        check("st_mem01", mem[8'h01], 8'h04);
        check("st_mem02", mem[8'h02], 8'h00);
        check("st_addr_hold", mem_addr, 8'h01);

        // 3: VADD v1 += v2
        issue(2'b00, 2'd1, 2'd0, 8'd20, 1'b0, bc, dc, ec, wc);
        issue(2'b00, 2'd2, 2'd0, 8'd24, 1'b0, bc, dc, ec, wc);
        dbg_sel = 2'd2; #1;
        check("ld_v2", dbg_vec, 32'h01808001);
        issue(2'b10, 2'd1, 2'd2, 8'h00, 1'b0, bc, dc, ec, wc);
        check("add_busy", bc, 3);
        dbg_sel = 2'd1; #1;
`ifdef VEC_SAT_EN
        check("add_v1", dbg_vec, 32'hFFFFFF02);
`else
        check("add_v1", dbg_vec, 32'h0000FF02);
`endif
        check("add_vzero", vzero, 1'b0);
        dbg_sel = 2'd2; #1;
        check("add_v2_kept", dbg_vec, 32'h01808001);

        // VADD v2 += v2 doubles the register
        issue(2'b10, 2'd2, 2'd2, 8'h00, 1'b0, bc, dc, ec, wc);
        dbg_sel = 2'd2; #1;
`ifdef VEC_SAT_EN
        check("dbl_v2", dbg_vec, 32'h02FFFF02);
`else
        check("dbl_v2", dbg_vec, 32'h02000002);
`endif

        // 4: VADD v0 += v0 on zero, then illegal op
        issue(2'b10, 2'd0, 2'd0, 8'h00, 1'b0, bc, dc, ec, wc);
        check("zadd_busy", bc, 3);
        check("zadd_vzero", vzero, 1'b1);
        issue(2'b11, 2'd1, 2'd2, 8'h10, 1'b0, bc, dc, ec, wc);
        check("ill_busy", bc, 1);
        check("ill_done", dc, 1);
        check("ill_err", ec, 1);
        check("ill_wren", wc, 0);
        check("ill_vzero", vzero, 1'b1);
        dbg_sel = 2'd1; #1;
`ifdef VEC_SAT_EN
        check("ill_v1", dbg_vec, 32'hFFFFFF02);
`else
        check("ill_v1", dbg_vec, 32'h0000FF02);
`endif

        // 5: restart during VLOAD is ignored
        issue(2'b00, 2'd3, 2'd0, 8'd10, 1'b1, bc, dc, ec, wc);
        check("rs_busy", bc, 7);
        check("rs_done", dc, 1);
        dbg_sel = 2'd3; #1;
        check("rs_v3", dbg_vec, 32'h04030201);
        dbg_sel = 2'd0; #1;
        check("rs_v0", dbg_vec, 32'h0);

        // Reset during LOAD cycle 2 aborts
        @(negedge clock); start = 1'b1; op = 2'b00; vdst = 2'd0; base_addr = 8'd20;
        @(negedge clock); start = 1'b0;
        check("abort_busy_pre", busy, 1'b1);
        @(negedge clock); reset = 1'b1; #1;
        check("abort_busy", busy, 1'b0);
        check("abort_wren", mem_wren, 1'b0);
        check("abort_done", done, 1'b0);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i); #1;
            check("abort_vreg", dbg_vec, 32'h0);
        end
        @(negedge clock); reset = 1'b0;
        @(negedge clock);
        check("abort_mem", mem[8'd20], 8'h01);
        check("abort_busy_post", busy, 1'b0);

        // 6: 8 lanes x 16 bits round trip
        for (int k = 0; k < 8; k++) begin
            poke8(8'h30 + 8'(k), 16'hA000 + 16'(k) * 16'h0101);
        end
        issue8(2'b00, 2'd2, 2'd0, 8'h30, bc, wc);
        check("w_ld_busy", bc, 11);
        dbg_sel8 = 2'd2; #1;
        check("w_ld_v2", dbg_vec8, 128'hA707_A606_A505_A404_A303_A202_A101_A000);
        issue8(2'b01, 2'd0, 2'd2, 8'hFC, bc, wc);
        check("w_st_busy", bc, 9);
        check("w_st_wren", wc, 8);
        for (int k = 0; k < 8; k++) begin
            check("w_st_mem", mem8[8'hFC + 8'(k)], 16'hA000 + 16'(k) * 16'h0101);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
